sprite_fetch: RTL and testbench



---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_hit.sv | 42 ++++
 rtl/sprite_fetch.sv | 147 ++++++++++++++
 tb/tb_sprite_fetch.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite fetch path:
// ROM layout, address/index widths, transparency.
package sprite_pkg;

  localparam int ADDR_W = 18;
  localparam int IDX_W  = 5;

  localparam logic [IDX_W-1:0] TRANSPARENT = '0;

  localparam logic [ADDR_W-1:0] CANNONBALL_BASE = 18'd0;
  localparam logic [ADDR_W-1:0] DEMO_R_RED_BASE = 18'd64;
  localparam logic [ADDR_W-1:0] DEMO_L_RED_BASE = 18'd490;
  localparam logic [ADDR_W-1:0] DEMO_R_BLU_BASE = 18'd916;
  localparam logic [ADDR_W-1:0] DEMO_L_BLU_BASE = 18'd1342;
  localparam logic [ADDR_W-1:0] BLANK_ADDR      = 18'd1706;
  localparam logic [ADDR_W-1:0] MAP1_BASE       = 18'd1707;
  localparam logic [ADDR_W-1:0] MAP2_BASE       = 18'd78507;

  function automatic logic [ADDR_W-1:0] map_base(input logic sel);
    return sel ? MAP2_BASE : MAP1_BASE;
  endfunction

endpackage

// File: rtl/sprite_hit.sv
// Per-object range test and row-major offset
// into the object's sprite image.
module sprite_hit
  import sprite_pkg::*;
(
  input  logic              en,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        obj_x,
  input  logic [9:0]        obj_y,
  input  logic [5:0]        obj_w,
  input  logic [5:0]        obj_h,
  input  logic [ADDR_W-1:0] base,
  output logic              hit,
  output logic [ADDR_W-1:0] addr
);

  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic [9:0]  w_dx;
  logic [9:0]  w_dy;
  logic [15:0] w_prod;

  // 11-bit ends so objects near the right edge clip, not wrap
  assign w_x_end = {1'b0, obj_x} + {5'b0, obj_w};
  assign w_y_end = {1'b0, obj_y} + {5'b0, obj_h};

  assign hit = en
    && (draw_x >= obj_x)
    && ({1'b0, draw_x} < w_x_end)
    && (draw_y >= obj_y)
    && ({1'b0, draw_y} < w_y_end);

  assign w_dx   = draw_x - obj_x;
  assign w_dy   = draw_y - obj_y;
  assign w_prod = 16'(w_dy) * 16'(obj_w);

  assign addr = base
    + {2'b0, w_prod}
    + {8'b0, w_dx};

endmodule

// File: rtl/sprite_fetch.sv
// Pixel address generator and compositor: one sprite
// and one background ROM read per pixel, 4-cycle latency.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int N_OBJ = 4,
  parameter int MAP_W = 320
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pixel_en,
  input  logic                  blank,
  input  logic [9:0]            draw_x,
  input  logic [9:0]            draw_y,
  input  logic                  map_sel,
  input  logic [N_OBJ-1:0]      obj_en,
  input  logic [N_OBJ*10-1:0]   obj_x,
  input  logic [N_OBJ*10-1:0]   obj_y,
  input  logic [N_OBJ*6-1:0]    obj_w,
  input  logic [N_OBJ*6-1:0]    obj_h,
  input  logic [N_OBJ*18-1:0]   obj_base,
  output logic [ADDR_W-1:0]     ram_addr,
  input  logic [IDX_W-1:0]      ram_q,
  output logic [IDX_W-1:0]      pix_idx,
  output logic                  pix_valid,
  output logic                  overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SPR   = 2'd1;
  localparam logic [1:0] S_BG    = 2'd2;
  localparam logic [1:0] S_MERGE = 2'd3;

  logic [N_OBJ-1:0]  w_hit;
  logic [ADDR_W-1:0] w_addr [N_OBJ];
  logic              w_any;
  logic [ADDR_W-1:0] w_spr_addr;
  logic [ADDR_W-1:0] w_bg_addr;
  logic              w_accept;
  logic [1:0]        w_next;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [ADDR_W-1:0] r_bg_addr;
  logic              r_hit_a;
  logic              r_hit_b;
  logic [IDX_W-1:0]  r_spr_q;
  logic              r_p1;
  logic              r_p2;
  logic              r_p3;
  logic [IDX_W-1:0]  r_pix_idx;
  logic              r_pix_valid;
  logic              r_ovr;

  for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
    sprite_hit u_hit (
      .en     (obj_en[g]),
      .draw_x (draw_x),
      .draw_y (draw_y),
      .obj_x  (obj_x[g*10 +: 10]),
      .obj_y  (obj_y[g*10 +: 10]),
      .obj_w  (obj_w[g*6 +: 6]),
      .obj_h  (obj_h[g*6 +: 6]),
      .base   (obj_base[g*18 +: 18]),
      .hit    (w_hit[g]),
      .addr   (w_addr[g])
    );
  end

  // scan high to low so the lowest index wins
  always_comb begin
    w_any      = 1'b0;
    w_spr_addr = BLANK_ADDR;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any      = 1'b1;
        w_spr_addr = w_addr[i];
      end
    end
  end

  assign w_bg_addr = map_base(map_sel)
    + 18'(draw_y[9:1]) * 18'(MAP_W)
    + 18'(draw_x[9:1]);

  assign w_accept = pixel_en && (r_state != S_SPR);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = w_accept ? S_SPR : S_IDLE;
      S_SPR:   w_next = S_BG;
      S_BG:    w_next = w_accept ? S_SPR : S_MERGE;
      S_MERGE: w_next = w_accept ? S_SPR : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ram_addr  <= '0;
      r_bg_addr   <= '0;
      r_hit_a     <= 1'b0;
      r_hit_b     <= 1'b0;
      r_spr_q     <= '0;
      r_p1        <= 1'b0;
      r_p2        <= 1'b0;
      r_p3        <= 1'b0;
      r_pix_idx   <= '0;
      r_pix_valid <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_p1        <= w_accept;
      r_p2        <= r_p1;
      r_p3        <= r_p2;
      r_pix_valid <= r_p3;
      if (pixel_en && r_state == S_SPR)
        r_ovr <= 1'b1;
      // no-hit pixels leave the address bus alone
      if (w_accept) begin
        r_hit_a   <= !blank && w_any;
        r_bg_addr <= blank ? BLANK_ADDR : w_bg_addr;
        if (blank)
          r_ram_addr <= BLANK_ADDR;
        else if (w_any)
          r_ram_addr <= w_spr_addr;
      end else if (r_state == S_SPR) begin
        r_ram_addr <= r_bg_addr;
      end
      if (r_p2) begin
        r_spr_q <= ram_q;
        r_hit_b <= r_hit_a;
      end
      if (r_p3)
        r_pix_idx <= (r_hit_b && r_spr_q != TRANSPARENT)
          ? r_spr_q : ram_q;
    end
  end

  assign ram_addr  = r_ram_addr;
  assign pix_idx   = r_pix_idx;
  assign pix_valid = r_pix_valid;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_sprite_fetch.sv
// Bench for sprite_fetch: ROM model, per-pixel
// reference model, per-cycle compare, directed cases.
module tb_sprite_fetch;

  localparam int N = 4;
  localparam int DEPTH = 8192;

  logic          clock;
  logic          reset;
  logic          pixel_en;
  logic          blank;
  logic [9:0]    draw_x;
  logic [9:0]    draw_y;
  logic          map_sel;
  logic [N-1:0]  obj_en;
  logic [N*10-1:0] obj_x;
  logic [N*10-1:0] obj_y;
  logic [N*6-1:0]  obj_w;
  logic [N*6-1:0]  obj_h;
  logic [N*18-1:0] obj_base;
  logic [17:0]   ram_addr;
  logic [4:0]    ram_q;
  logic [4:0]    pix_idx;
  logic          pix_valid;
  logic          overrun;

  sprite_fetch #(.N_OBJ(N), .MAP_W(320)) dut (
    .clock    (clock),
    .reset    (reset),
    .pixel_en (pixel_en),
    .blank    (blank),
    .draw_x   (draw_x),
    .draw_y   (draw_y),
    .map_sel  (map_sel),
    .obj_en   (obj_en),
    .obj_x    (obj_x),
    .obj_y    (obj_y),
    .obj_w    (obj_w),
    .obj_h    (obj_h),
    .obj_base (obj_base),
    .ram_addr (ram_addr),
    .ram_q    (ram_q),
    .pix_idx  (pix_idx),
    .pix_valid(pix_valid),
    .overrun  (overrun)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  // ROM contents: addr mod 29, with up to two overrides
  int          ov_n = 0;
  logic [17:0] ov_a [2];
  logic [4:0]  ov_d [2];

  function automatic int rom(input int a);
    for (int i = 0; i < 2; i++)
      if (i < ov_n && a == int'(ov_a[i])) return int'(ov_d[i]);
    return a % 29;
  endfunction

  always @(posedge clock) ram_q <= 5'(rom(int'(ram_addr)));

  // reference model, indexed by cycle number
  int cyc = 0;
  int last_acc = -10;
  bit exp_v  [DEPTH];
  int exp_i  [DEPTH];
  bit exp_ac [DEPTH];
  int exp_a  [DEPTH];
  bit exp_ovr = 0;

  task automatic model_pixel(input int c);
    int dx, dy, hi, spr, bg, ox, oy, w, h, b, sd;
    dx = int'(draw_x);
    dy = int'(draw_y);
    hi = -1;
    spr = 0;
    if (!blank) begin
      for (int i = N - 1; i >= 0; i--) begin
        ox = int'(obj_x[i*10 +: 10]);
        oy = int'(obj_y[i*10 +: 10]);
        w  = int'(obj_w[i*6 +: 6]);
        h  = int'(obj_h[i*6 +: 6]);
        b  = int'(obj_base[i*18 +: 18]);
        if (obj_en[i] && dx >= ox && dx < ox + w
            && dy >= oy && dy < oy + h) begin
          hi  = i;
          spr = (b + (dy - oy) * w + (dx - ox)) % 262144;
        end
      end
      bg = (map_sel ? 78507 : 1707) + (dy / 2) * 320 + dx / 2;
    end else begin
      bg = 1706;
    end
    if (c + 4 < DEPTH) begin
      if (blank) begin
        exp_ac[c+1] = 1; exp_a[c+1] = 1706;
      end else if (hi >= 0) begin
        exp_ac[c+1] = 1; exp_a[c+1] = spr;
      end
      exp_ac[c+2] = 1; exp_a[c+2] = bg;
      sd = rom(spr);
      exp_v[c+4] = 1;
      exp_i[c+4] = (hi >= 0 && sd != 0) ? sd : rom(bg);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      for (int k = cyc + 1; k <= cyc + 4 && k < DEPTH; k++) begin
        exp_v[k]  = 0;
        exp_ac[k] = 0;
      end
      last_acc = -10;
      exp_ovr  = 0;
    end else if (pixel_en) begin
      if (last_acc == cyc - 1) exp_ovr = 1;
      else begin
        last_acc = cyc;
        model_pixel(cyc);
      end
    end
    cyc++;
  end

  always @(negedge clock) begin
    if (cyc > 0 && cyc < DEPTH) begin
      chk("pix_valid", int'(pix_valid), int'(exp_v[cyc]));
      if (exp_v[cyc]) chk("pix_idx", int'(pix_idx), exp_i[cyc]);
      if (exp_ac[cyc]) chk("ram_addr", int'(ram_addr), exp_a[cyc]);
      chk("overrun", int'(overrun), int'(exp_ovr));
    end
  end

  task automatic set_obj(input int i, input bit en, input int x,
                         input int y, input int w, input int h,
                         input int b);
    obj_en[i] = en;
    obj_x[i*10 +: 10] = 10'(x);
    obj_y[i*10 +: 10] = 10'(y);
    obj_w[i*6 +: 6]   = 6'(w);
    obj_h[i*6 +: 6]   = 6'(h);
    obj_base[i*18 +: 18] = 18'(b);
  endtask

  // called at a falling edge; returns in cycle t+1
  task automatic strobe(input int x, input int y);
    pixel_en = 1'b1;
    draw_x = 10'(x);
    draw_y = 10'(y);
    @(negedge clock);
    pixel_en = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clock);
  endtask

  int q3;
  int cnt;

  initial begin
    reset = 1'b1;
    pixel_en = 1'b0;
    blank = 1'b0;
    draw_x = '0;
    draw_y = '0;
    map_sel = 1'b0;
    obj_en = '0;
    obj_x = '0;
    obj_y = '0;
    obj_w = '0;
    obj_h = '0;
    obj_base = '0;
    gap(2);
    reset = 1'b0;
    chk("rst ram_addr", int'(ram_addr), 0);
    chk("rst pix_idx", int'(pix_idx), 0);
    chk("rst pix_valid", int'(pix_valid), 0);
    chk("rst overrun", int'(overrun), 0);
    gap(1);

    // background only at the origin
    strobe(0, 0);
    gap(1);
    chk("t1 bg addr", int'(ram_addr), 1707);
    gap(1);
    chk("t1 valid t+3", int'(pix_valid), 0);
    q3 = int'(ram_q);
    gap(1);
    chk("t1 valid t+4", int'(pix_valid), 1);
    chk("t1 idx=ram_q", int'(pix_idx), q3);
    chk("t1 idx lit", int'(pix_idx), 25);
    gap(3);

    // single object, transparent then opaque sprite texel
    set_obj(0, 1, 100, 50, 15, 25, 204);
    ov_n = 2;
    ov_a[0] = 18'd237;   ov_d[0] = 5'd0;
    ov_a[1] = 18'd10078; ov_d[1] = 5'd7;
    strobe(103, 52);
    chk("t2 spr addr", int'(ram_addr), 237);
    gap(1);
    chk("t2 bg addr", int'(ram_addr), 10078);
    gap(2);
    chk("t2 valid", int'(pix_valid), 1);
    chk("t2 idx bg", int'(pix_idx), 7);
    gap(3);
    ov_d[0] = 5'd12;
    strobe(103, 52);
    gap(3);
    chk("t2 idx spr", int'(pix_idx), 12);
    gap(3);
    ov_n = 0;

    // overlap priority
    set_obj(1, 1, 105, 55, 20, 20, 3000);
    strobe(110, 60);
    chk("t3 obj0 addr", int'(ram_addr), 364);
    gap(5);
    obj_en[0] = 1'b0;
    strobe(110, 60);
    chk("t3 obj1 addr", int'(ram_addr), 3105);
    gap(5);
    obj_en[0] = 1'b1;

    // blanking
    blank = 1'b1;
    strobe(110, 60);
    chk("t4 spr blank", int'(ram_addr), 1706);
    gap(1);
    blank = 1'b0;
    chk("t4 bg blank", int'(ram_addr), 1706);
    gap(2);
    chk("t4 valid", int'(pix_valid), 1);
    chk("t4 idx", int'(pix_idx), 24);
    gap(3);

    // back-to-back strobes
    pixel_en = 1'b1;
    draw_x = 10'd5; draw_y = 10'd5;
    @(negedge clock);
    draw_x = 10'd6; draw_y = 10'd6;
    @(negedge clock);
    pixel_en = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clock);
      if (pix_valid) cnt++;
    end
    chk("t5 pulses", cnt, 1);
    chk("t5 overrun", int'(overrun), 1);

    // full line with a mid-line reset
    reset = 1'b1;
    gap(1);
    reset = 1'b0;
    chk("t6 ovr clr", int'(overrun), 0);
    map_sel = 1'b1;
    set_obj(0, 1, 300, 8, 10, 5, 500);
    set_obj(2, 1, 630, 0, 40, 63, 7000);
    set_obj(3, 1, 0, 0, 63, 63, 260000);
    gap(1);
    for (int x = 0; x < 640; x++) begin
      if (x == 320) begin
        reset = 1'b1;
        gap(1);
        reset = 1'b0;
        cnt = 0;
        repeat (6) begin
          @(negedge clock);
          if (pix_valid) cnt++;
        end
        chk("t6 no stale", cnt, 0);
      end
      strobe(x, 10);
      gap(1);
    end
    chk("t6 line ovr", int'(overrun), 0);
    gap(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
